hs_fifo: RTL and testbench
==========================

HS_FIFO -- requirements
Module: hs_fifo

Interface
REQ-001 Parameter data_width, default 32, payload width in bits.
REQ-002 Parameter depth, default 4, entry count; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 in_req  output  1  pull request to the upstream source.
REQ-006 in_ack  input  1  upstream one-cycle data strobe.
REQ-007 in_data  input  data_width  upstream payload, valid while in_ack=1.
REQ-008 out_req  input  1  pull request from the downstream sink.
REQ-009 out_ack  output  1  one-cycle data strobe to the downstream sink.
REQ-010 out_data  output  data_width  payload, valid while out_ack=1, held otherwise.
REQ-011 ovf  output  1  sticky protocol-violation flag.

Function
REQ-012 The block shall be a circular buffer of depth entries with read pointer, write pointer and a 0..depth occupancy counter.
REQ-013 in_req shall be combinational: high exactly when occupancy < depth, so a full FIFO never requests.
REQ-014 Push: on an edge with in_ack=1 and occupancy < depth, the block shall write in_data at the write pointer, increment the write pointer modulo depth, and increment occupancy.
REQ-015 Pop: on an edge with out_req=1, out_ack=0 and occupancy > 0, the block shall register the head entry into out_data, set out_ack=1 for exactly one cycle, advance the read pointer modulo depth, and decrement occupancy.
REQ-016 out_ack shall clear on the edge after it is set; per-sink throughput is therefore at most one word per two cycles.
REQ-017 A simultaneous push and pop on the same edge shall leave occupancy unchanged. Both pointers advance.
REQ-018 A pop shall use only the occupancy before the edge, so a word pushed on edge t is first poppable on edge t+1.
REQ-019 Minimum in_ack-to-out_ack latency shall be 1 cycle.
REQ-020 Empty with out_req=1: out_ack shall stay 0 and out_data shall hold its last value.
REQ-021 in_ack=1 while occupancy = depth shall discard the word, leave all pointers and occupancy unchanged, and set ovf=1.
REQ-022 ovf shall clear only on reset.
REQ-023 Pointer wrap-around shall be seamless. Words shall leave in exactly arrival order across any number of wraps.
REQ-024 out_data shall change only on edges where out_ack is set.

Reset
REQ-025 rst=0 shall immediately, without waiting for clk, clear occupancy, both pointers, out_ack, out_data (to 0) and ovf.
REQ-026 Storage contents shall not be reset.
REQ-027 Reset asserted mid-transfer shall drop all buffered words. After release, the first popped word shall be the first word pushed after release.
REQ-028 in_req shall be 1 during and after reset, since occupancy = 0.

Configuration
REQ-029 Macro HS_FIFO_COUNT_EN defined: the block shall add outputs in_count and out_count, 32 bits each.
REQ-030 With HS_FIFO_COUNT_EN, in_count and out_count shall be reset to 0, increment on each accepted push and each pop respectively, and wrap at 2^32.
REQ-031 Macro HS_FIFO_COUNT_EN undefined: in_count, out_count and their logic shall be absent. All other behaviour shall be identical.

Verification
REQ-032 Fill: depth=4, out_req=0, source acks values 0..3 every other cycle. Required: in_req falls after the 4th push, no further push occurs, ovf=0.
REQ-033 Drain: from the full state, out_req=1 held. Required: out_ack pulses on alternate cycles with out_data 0,1,2,3. in_req rises after the first pop. No out_ack is issued once empty.
REQ-034 Streaming: source and sink both at maximum rate, 5000 words 0..4999 through depth=4. Required: in-order delivery with no loss, occupancy stays <= 2, and throughput equals the source rate.
REQ-035 Overflow: full FIFO, force in_ack=1 with in_data=0xDEAD. Required: ovf=1, 0xDEAD is never output, and the next four pops return the original contents.
REQ-036 Async reset: 3 words buffered, assert rst=0 between edges. Required: out_ack=0 and ovf=0 immediately. After release, push 0x55. Required: the first pop returns 0x55.
REQ-037 Count build (HS_FIFO_COUNT_EN): after 10 pushes and 7 pops, in_count=10 and out_count=7. A reset returns both to 0.

Source files
------------

// File: rtl/hs_fifo.sv
// hs_fifo: pull-handshake circular FIFO with a sticky overflow flag.
// Defining HS_FIFO_COUNT_EN adds the 32-bit in_count/out_count transfer counters.
module hs_fifo #(
    parameter int data_width = 32,
    parameter int depth      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  in_req,
    input  logic                  in_ack,
    input  logic [data_width-1:0] in_data,
    input  logic                  out_req,
    output logic                  out_ack,
    output logic [data_width-1:0] out_data,
`ifdef HS_FIFO_COUNT_EN
    output logic [31:0]           in_count,
    output logic [31:0]           out_count,
`endif
    output logic                  ovf
);

    localparam int              aw         = $clog2(depth);
    localparam logic [aw:0]     depth_c    = (aw+1)'(depth);
    localparam logic [aw:0]     cnt_one_c  = (aw+1)'(1);
    localparam logic [aw:0]     cnt_zero_c = (aw+1)'(0);
    localparam logic [aw-1:0]   ptr_one_c  = (aw)'(1);
    localparam logic [aw-1:0]   ptr_zero_c = (aw)'(0);

    logic [data_width-1:0] mem_r [0:depth-1];
    logic [aw-1:0]         wr_ptr_r;
    logic [aw-1:0]         rd_ptr_r;
    logic [aw:0]           count_r;
    logic                  out_ack_r;
    logic [data_width-1:0] out_data_r;
    logic                  ovf_r;

    logic                  full_s;
    logic                  empty_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  drop_s;
    logic [aw:0]           count_nxt_s;

    // Handshake decode; a pop only looks at occupancy before the edge.
    always_comb begin
        full_s      = 1'b0;
        empty_s     = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        drop_s      = 1'b0;
        count_nxt_s = count_r;

        full_s  = (count_r == depth_c);
        empty_s = (count_r == cnt_zero_c);
        push_s  = in_ack & ~full_s;
        pop_s   = out_req & ~out_ack_r & ~empty_s;
        drop_s  = in_ack & full_s;

        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + cnt_one_c;
            2'b01:   count_nxt_s = count_r - cnt_one_c;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy, output strobe/data and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= ptr_zero_c;
            rd_ptr_r   <= ptr_zero_c;
            count_r    <= cnt_zero_c;
            out_ack_r  <= 1'b0;
            out_data_r <= {data_width{1'b0}};
            ovf_r      <= 1'b0;
        end else begin
            count_r   <= count_nxt_s;
            out_ack_r <= pop_s;
            ovf_r     <= ovf_r | drop_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ptr_one_c;
            end
            if (pop_s) begin
                out_data_r <= mem_r[rd_ptr_r];
                rd_ptr_r   <= rd_ptr_r + ptr_one_c;
            end
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

`ifdef HS_FIFO_COUNT_EN
    logic [31:0] in_count_r;
    logic [31:0] out_count_r;

    // Free-running transfer counters, wrapping naturally at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_count_r  <= 32'd0;
            out_count_r <= 32'd0;
        end else begin
            if (push_s) begin
                in_count_r <= in_count_r + 32'd1;
            end
            if (pop_s) begin
                out_count_r <= out_count_r + 32'd1;
            end
        end
    end

    assign in_count  = in_count_r;
    assign out_count = out_count_r;
`endif

    assign in_req   = ~full_s;
    assign out_ack  = out_ack_r;
    assign out_data = out_data_r;
    assign ovf      = ovf_r;

endmodule

// File: tb/tb_hs_fifo.sv
// tb_hs_fifo: directed self-checking bench for hs_fifo (depth 4, 32-bit data).
// Build with HS_FIFO_COUNT_EN defined to also exercise the transfer counters.
module tb_hs_fifo;

    logic        clk;
    logic        rst;
    logic        in_req;
    logic        in_ack;
    logic [31:0] in_data;
    logic        out_req;
    logic        out_ack;
    logic [31:0] out_data;
    logic        ovf;
`ifdef HS_FIFO_COUNT_EN
    logic [31:0] in_count;
    logic [31:0] out_count;
`endif

    int test_cnt;
    int fail_cnt;

    hs_fifo #(.data_width(32), .depth(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_req   (in_req),
        .in_ack   (in_ack),
        .in_data  (in_data),
        .out_req  (out_req),
        .out_ack  (out_ack),
        .out_data (out_data),
`ifdef HS_FIFO_COUNT_EN
        .in_count (in_count),
        .out_count(out_count),
`endif
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_word(input logic [31:0] v);
        @(negedge clk);
        in_ack  = 1'b1;
        in_data = v;
        @(negedge clk);
        in_ack  = 1'b0;
    endtask

    task automatic pop_n(input int n, output int got);
        got     = 0;
        out_req = 1'b1;
        for (int c = 0; c < 8 * n && got < n; c++) begin
            @(negedge clk);
            if (out_ack === 1'b1) got++;
        end
        out_req = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_cnt++;
        if (in_req !== 1'b1 || out_ack !== 1'b0 || ovf !== 1'b0 || out_data !== 32'h0) begin
            fail_cnt++;
            $display("FAIL reset_state: in_req=%b out_ack=%b ovf=%b out_data=%h, expected 1 0 0 00000000",
                     in_req, out_ack, ovf, out_data);
        end
        rst = 1'b1;
        @(negedge clk);
        test_cnt++;
        if (in_req !== 1'b1) begin
            fail_cnt++;
            $display("FAIL reset_release_req: in_req=%b expected 1", in_req);
        end
    endtask

    task automatic test_fill;
        logic exp_req;
        out_req = 1'b0;
        for (int v = 0; v < 4; v++) begin
            @(negedge clk);
            test_cnt++;
            if (in_req !== 1'b1) begin
                fail_cnt++;
                $display("FAIL fill_req_before_%0d: in_req=%b expected 1", v, in_req);
            end
            in_ack  = 1'b1;
            in_data = 32'(v);
            @(negedge clk);
            in_ack  = 1'b0;
            exp_req = (v < 3) ? 1'b1 : 1'b0;
            test_cnt++;
            if (in_req !== exp_req) begin
                fail_cnt++;
                $display("FAIL fill_req_after_%0d: in_req=%b expected %b", v, in_req, exp_req);
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            test_cnt++;
            if (in_req !== 1'b0 || ovf !== 1'b0 || out_ack !== 1'b0) begin
                fail_cnt++;
                $display("FAIL fill_hold: in_req=%b ovf=%b out_ack=%b expected 0 0 0", in_req, ovf, out_ack);
            end
        end
    endtask

    task automatic test_drain;
        @(negedge clk);
        test_cnt++;
        if (in_req !== 1'b0) begin
            fail_cnt++;
            $display("FAIL drain_full_req: in_req=%b expected 0", in_req);
        end
        out_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            test_cnt++;
            if (out_ack !== 1'b1 || out_data !== 32'(i)) begin
                fail_cnt++;
                $display("FAIL drain_pop_%0d: out_ack=%b out_data=%h expected 1 %h", i, out_ack, out_data, 32'(i));
            end
            if (i == 0) begin
                test_cnt++;
                if (in_req !== 1'b1) begin
                    fail_cnt++;
                    $display("FAIL drain_req_rise: in_req=%b expected 1", in_req);
                end
            end
            @(negedge clk);
            test_cnt++;
            if (out_ack !== 1'b0 || out_data !== 32'(i)) begin
                fail_cnt++;
                $display("FAIL drain_gap_%0d: out_ack=%b out_data=%h expected 0 %h", i, out_ack, out_data, 32'(i));
            end
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            test_cnt++;
            if (out_ack !== 1'b0 || out_data !== 32'd3) begin
                fail_cnt++;
                $display("FAIL drain_empty: out_ack=%b out_data=%h expected 0 00000003", out_ack, out_data);
            end
        end
        out_req = 1'b0;
    endtask

    task automatic test_stream;
        int tx;
        int rx;
        int occ;
        int max_occ;
        int cyc;
        tx      = 0;
        rx      = 0;
        max_occ = 0;
        out_req = 1'b1;
        for (cyc = 0; cyc < 12000 && rx < 5000; cyc++) begin
            @(negedge clk);
            if (out_ack === 1'b1) begin
                test_cnt++;
                if (out_data !== 32'(rx)) begin
                    fail_cnt++;
                    $display("FAIL stream_word_%0d: out_data=%h expected %h", rx, out_data, 32'(rx));
                end
                rx++;
            end
            occ = tx - rx;
            if (occ > max_occ) max_occ = occ;
            if (in_ack === 1'b1) begin
                in_ack = 1'b0;
            end else if (tx < 5000 && in_req === 1'b1) begin
                in_ack  = 1'b1;
                in_data = 32'(tx);
                tx++;
            end
        end
        in_ack  = 1'b0;
        out_req = 1'b0;
        test_cnt++;
        if (rx != 5000) begin
            fail_cnt++;
            $display("FAIL stream_count: received %0d words, expected 5000", rx);
        end
        test_cnt++;
        if (max_occ > 2) begin
            fail_cnt++;
            $display("FAIL stream_occupancy: max occupancy %0d, expected <= 2", max_occ);
        end
        test_cnt++;
        if (cyc > 10004) begin
            fail_cnt++;
            $display("FAIL stream_throughput: took %0d cycles, expected <= 10004", cyc);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_overflow;
        int got;
        out_req = 1'b0;
        for (int i = 0; i < 4; i++) push_word(32'h100 + 32'(i));
        test_cnt++;
        if (in_req !== 1'b0 || ovf !== 1'b0) begin
            fail_cnt++;
            $display("FAIL ovf_pre: in_req=%b ovf=%b expected 0 0", in_req, ovf);
        end
        @(negedge clk);
        in_ack  = 1'b1;
        in_data = 32'hDEAD;
        @(negedge clk);
        test_cnt++;
        if (ovf !== 1'b1) begin
            fail_cnt++;
            $display("FAIL ovf_set: ovf=%b expected 1", ovf);
        end
        @(negedge clk);
        in_ack = 1'b0;
        repeat (2) @(negedge clk);
        test_cnt++;
        if (ovf !== 1'b1 || in_req !== 1'b0) begin
            fail_cnt++;
            $display("FAIL ovf_sticky: ovf=%b in_req=%b expected 1 0", ovf, in_req);
        end
        got     = 0;
        out_req = 1'b1;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            if (out_ack === 1'b1) begin
                test_cnt++;
                if (out_data !== 32'h100 + 32'(got)) begin
                    fail_cnt++;
                    $display("FAIL ovf_pop_%0d: out_data=%h expected %h", got, out_data, 32'h100 + 32'(got));
                end
                got++;
            end
        end
        test_cnt++;
        if (got != 4) begin
            fail_cnt++;
            $display("FAIL ovf_pop_count: popped %0d, expected 4", got);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            test_cnt++;
            if (out_ack !== 1'b0) begin
                fail_cnt++;
                $display("FAIL ovf_extra_pop: out_ack=%b out_data=%h expected no strobe", out_ack, out_data);
            end
        end
        out_req = 1'b0;
    endtask

    task automatic test_async_reset;
        out_req = 1'b0;
        push_word(32'h11);
        push_word(32'h22);
        push_word(32'h33);
        out_req = 1'b1;
        @(negedge clk);
        out_req = 1'b0;
        test_cnt++;
        if (out_ack !== 1'b1 || out_data !== 32'h11) begin
            fail_cnt++;
            $display("FAIL ares_pre_pop: out_ack=%b out_data=%h expected 1 00000011", out_ack, out_data);
        end
        #2 rst = 1'b0;
        #1;
        test_cnt++;
        if (out_ack !== 1'b0 || ovf !== 1'b0 || out_data !== 32'h0 || in_req !== 1'b1) begin
            fail_cnt++;
            $display("FAIL ares_immediate: out_ack=%b ovf=%b out_data=%h in_req=%b expected 0 0 00000000 1",
                     out_ack, ovf, out_data, in_req);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        in_ack  = 1'b1;
        in_data = 32'h55;
        out_req = 1'b1;
        @(negedge clk);
        in_ack = 1'b0;
        test_cnt++;
        if (out_ack !== 1'b0) begin
            fail_cnt++;
            $display("FAIL ares_same_edge_pop: out_ack=%b expected 0", out_ack);
        end
        @(negedge clk);
        test_cnt++;
        if (out_ack !== 1'b1 || out_data !== 32'h55) begin
            fail_cnt++;
            $display("FAIL ares_first_pop: out_ack=%b out_data=%h expected 1 00000055", out_ack, out_data);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            test_cnt++;
            if (out_ack !== 1'b0) begin
                fail_cnt++;
                $display("FAIL ares_stale_word: out_ack=%b out_data=%h expected no strobe", out_ack, out_data);
            end
        end
        out_req = 1'b0;
    endtask

`ifdef HS_FIFO_COUNT_EN
    task automatic test_count;
        int got;
        int total;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst   = 1'b1;
        total = 0;
        for (int i = 0; i < 4; i++) push_word(32'(i));
        pop_n(4, got);
        total += got;
        for (int i = 0; i < 4; i++) push_word(32'(i));
        pop_n(3, got);
        total += got;
        push_word(32'd8);
        push_word(32'd9);
        test_cnt++;
        if (total != 7) begin
            fail_cnt++;
            $display("FAIL count_pops: popped %0d, expected 7", total);
        end
        test_cnt++;
        if (in_count !== 32'd10 || out_count !== 32'd7) begin
            fail_cnt++;
            $display("FAIL count_values: in_count=%0d out_count=%0d expected 10 7", in_count, out_count);
        end
        #2 rst = 1'b0;
        #1;
        test_cnt++;
        if (in_count !== 32'd0 || out_count !== 32'd0) begin
            fail_cnt++;
            $display("FAIL count_reset: in_count=%0d out_count=%0d expected 0 0", in_count, out_count);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask
`endif

    initial begin
        test_cnt = 0;
        fail_cnt = 0;
        rst      = 1'b0;
        in_ack   = 1'b0;
        in_data  = 32'h0;
        out_req  = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_overflow();
        test_async_reset();
`ifdef HS_FIFO_COUNT_EN
        test_count();
`endif
        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
